// File: rtl/pll_reconfig_seq_if.sv
// Avalon-MM management bus between the PLL reconfiguration sequencer and pll_cfg.
interface pll_reconfig_seq_if;
    logic        mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;

    modport master (output mgmt_write, mgmt_address, mgmt_writedata, input mgmt_waitrequest);
    modport slave  (input mgmt_write, mgmt_address, mgmt_writedata, output mgmt_waitrequest);
endinterface

// File: rtl/pll_reconfig_seq.sv
// Reprograms the SDRAM-clock PLL via pll_cfg: frequency register writes, PLL reset pulse,
// lock wait, then an optional dynamic phase step.
module pll_reconfig_seq #(
    parameter int GAP_CYCLES   = 7,
    parameter int RST_CYCLES   = 8,
    parameter int LOCK_TIMEOUT = 1048576
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [31:0]                cfg_m,
    input  logic [31:0]                cfg_k,
    input  logic [31:0]                cfg_c,
    input  logic [8:0]                 phase_base,
    input  logic [8:0]                 phase_target,
    input  logic                       locked,
    pll_reconfig_seq_if.master         mgmt,
    output logic                       pll_reset,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);
    localparam int CW = $clog2(LOCK_TIMEOUT + GAP_CYCLES + RST_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_GAP, S_RST, S_LOCKW, S_FIN} state_t;

    // Entry <idx> of the frequency list (ph=0) or phase list (ph=1), packed as {addr, data}.
    function automatic logic [37:0] wr_entry(input logic [3:0] idx, input logic ph,
                                             input logic [31:0] m, input logic [31:0] k,
                                             input logic [31:0] c, input logic [31:0] pd);
        logic [37:0] e;
        if (ph) begin
            case (idx)
                4'd1:    e = {6'd6, pd};
                4'd2:    e = {6'd2, 32'd0};
                default: e = {6'd0, 32'd0};
            endcase
        end else begin
            case (idx)
                4'd1:    e = {6'd4, m};
                4'd2:    e = {6'd7, k};
                4'd3:    e = {6'd3, 32'h0001_0000};
                4'd4:    e = {6'd5, c};
                4'd5:    e = {6'd5, c | 32'h0004_0000};
                4'd6:    e = {6'd9, 32'd1};
                4'd7:    e = {6'd8, 32'd7};
                4'd8:    e = {6'd2, 32'd0};
                default: e = {6'd0, 32'd0};
            endcase
        end
        return e;
    endfunction

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        in_ph_q, in_ph_d;
    logic [31:0] cfg_m_q, cfg_m_d, cfg_k_q, cfg_k_d, cfg_c_q, cfg_c_d;
    logic [8:0]  base_q, base_d, tgt_q, tgt_d;
    logic        lock_s1_q, lock_s2_q;
    logic        mgmt_write_q, mgmt_write_d;
    logic [5:0]  mgmt_address_q, mgmt_address_d;
    logic [31:0] mgmt_writedata_q, mgmt_writedata_d;
    logic        pll_reset_q, pll_reset_d;
    logic        busy_q, busy_d, done_q, done_d, error_q, error_d;

    logic [9:0]  ph_diff_s, ph_mag_s;
    logic [31:0] ph_data_s;
    logic [3:0]  last_idx_s;
    logic [37:0] next_entry_s;

    // The phase word carries the magnitude, the C1 counter select and the direction bit.
    assign ph_diff_s    = {1'b0, tgt_q} - {1'b0, base_q};
    assign ph_mag_s     = ph_diff_s[9] ? (10'd0 - ph_diff_s) : ph_diff_s;
    assign ph_data_s    = 32'h0001_0000 | {22'd0, ph_mag_s} | (ph_diff_s[9] ? 32'h0020_0000 : 32'h0000_0000);
    assign last_idx_s   = in_ph_q ? 4'd2 : 4'd8;
    assign next_entry_s = wr_entry(idx_q + 4'd1, in_ph_q, cfg_m_q, cfg_k_q, cfg_c_q, ph_data_s);

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        idx_d            = idx_q;
        in_ph_d          = in_ph_q;
        cfg_m_d          = cfg_m_q;
        cfg_k_d          = cfg_k_q;
        cfg_c_d          = cfg_c_q;
        base_d           = base_q;
        tgt_d            = tgt_q;
        mgmt_write_d     = mgmt_write_q;
        mgmt_address_d   = mgmt_address_q;
        mgmt_writedata_d = mgmt_writedata_q;
        pll_reset_d      = pll_reset_q;
        busy_d           = busy_q;
        done_d           = 1'b0;
        error_d          = error_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_m_d          = cfg_m;
                    cfg_k_d          = cfg_k;
                    cfg_c_d          = cfg_c;
                    base_d           = phase_base;
                    tgt_d            = phase_target;
                    busy_d           = 1'b1;
                    error_d          = 1'b0;
                    idx_d            = 4'd0;
                    in_ph_d          = 1'b0;
                    mgmt_write_d     = 1'b1;
                    mgmt_address_d   = 6'd0;
                    mgmt_writedata_d = 32'd0;
                    state_d          = S_WR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                if (mgmt_write_q && !mgmt.mgmt_waitrequest) begin
                    mgmt_write_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = S_GAP;
                end else begin
                    state_d = S_WR;
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (idx_q != last_idx_s) begin
                        idx_d            = idx_q + 4'd1;
                        mgmt_write_d     = 1'b1;
                        mgmt_address_d   = next_entry_s[37:32];
                        mgmt_writedata_d = next_entry_s[31:0];
                        state_d          = S_WR;
                    end else if (in_ph_q) begin
                        state_d = S_FIN;
                    end else begin
                        pll_reset_d = 1'b1;
                        state_d     = S_RST;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RST: begin
                if (cnt_q == CW'(RST_CYCLES - 1)) begin
                    pll_reset_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_LOCKW;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LOCKW: begin
                // A lock seen before two cycles have passed may be stale from before the reset.
                if (lock_s2_q && (cnt_q >= CW'(2))) begin
                    if (ph_diff_s == 10'd0) begin
                        state_d = S_FIN;
                    end else begin
                        in_ph_d          = 1'b1;
                        idx_d            = 4'd0;
                        mgmt_write_d     = 1'b1;
                        mgmt_address_d   = 6'd0;
                        mgmt_writedata_d = 32'd0;
                        state_d          = S_WR;
                    end
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, latched configuration, lock synchroniser and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            idx_q            <= 4'd0;
            in_ph_q          <= 1'b0;
            cfg_m_q          <= 32'd0;
            cfg_k_q          <= 32'd0;
            cfg_c_q          <= 32'd0;
            base_q           <= 9'd0;
            tgt_q            <= 9'd0;
            lock_s1_q        <= 1'b0;
            lock_s2_q        <= 1'b0;
            mgmt_write_q     <= 1'b0;
            mgmt_address_q   <= 6'd0;
            mgmt_writedata_q <= 32'd0;
            pll_reset_q      <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            error_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            idx_q            <= idx_d;
            in_ph_q          <= in_ph_d;
            cfg_m_q          <= cfg_m_d;
            cfg_k_q          <= cfg_k_d;
            cfg_c_q          <= cfg_c_d;
            base_q           <= base_d;
            tgt_q            <= tgt_d;
            lock_s1_q        <= locked;
            lock_s2_q        <= lock_s1_q;
            mgmt_write_q     <= mgmt_write_d;
            mgmt_address_q   <= mgmt_address_d;
            mgmt_writedata_q <= mgmt_writedata_d;
            pll_reset_q      <= pll_reset_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            error_q          <= error_d;
        end
    end

    assign mgmt.mgmt_write     = mgmt_write_q;
    assign mgmt.mgmt_address   = mgmt_address_q;
    assign mgmt.mgmt_writedata = mgmt_writedata_q;
    assign pll_reset           = pll_reset_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign error               = error_q;
endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Bench for pll_reconfig_seq: table of settings run back to back against an Avalon slave model
// with a write scoreboard, plus lock timeout, busy-start and mid-sequence reset sequences.
module tb_pll_reconfig_seq;
    localparam int LOCK_TO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        locked = 1'b0;
    logic [31:0] cfg_m = 32'd0, cfg_k = 32'd0, cfg_c = 32'd0;
    logic [8:0]  phase_base = 9'd0, phase_target = 9'd0;
    logic        pll_reset, busy, done, error;

    pll_reconfig_seq_if mif();

    pll_reconfig_seq #(.GAP_CYCLES(7), .RST_CYCLES(8), .LOCK_TIMEOUT(LOCK_TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_c(cfg_c),
        .phase_base(phase_base), .phase_target(phase_target), .locked(locked), .mgmt(mif),
        .pll_reset(pll_reset), .busy(busy), .done(done), .error(error));

    always #5 clk = ~clk;

    typedef struct { logic [5:0] a; logic [31:0] d; } wr_t;
    typedef struct {
        logic [31:0] m, k, c;
        logic [8:0]  base, tgt;
        int          wait_n;
        bit          lock_ok;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    wr_t  sb[$];
    vec_t vecs[6];
    int   n_chk = 0, n_fail = 0;
    int   wait_n = 0;
    bit   lock_ok = 1'b1;
    int   err_at = 0, done_cnt = 0, wr_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input logic [5:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        sb.push_back(e);
    endtask

    // Reference write list for one setting.
    task automatic push_expected(input vec_t v);
        int d, mag;
        logic [31:0] pd;
        push_wr(6'd0, 32'd0);
        push_wr(6'd4, v.m);
        push_wr(6'd7, v.k);
        push_wr(6'd3, 32'h0001_0000);
        push_wr(6'd5, v.c);
        push_wr(6'd5, v.c | 32'h0004_0000);
        push_wr(6'd9, 32'd1);
        push_wr(6'd8, 32'd7);
        push_wr(6'd2, 32'd0);
        d = int'(v.tgt) - int'(v.base);
        mag = (d < 0) ? -d : d;
        if (v.lock_ok && d != 0) begin
            pd = 32'h0001_0000 | 32'(mag) | ((d < 0) ? 32'h0020_0000 : 32'h0);
            push_wr(6'd0, 32'd0);
            push_wr(6'd6, pd);
            push_wr(6'd2, 32'd0);
        end
    endtask

    // Slave model: waitrequest, write checks, reset-pulse width, lock model, event counters.
    initial begin : mon
        int hold, rst_hi, rel_cnt, idle;
        bit pending, just_done, rel_active, prev_err, saw_break;
        logic [5:0]  cur_a;
        logic [31:0] cur_d;
        wr_t e;
        hold = 0; rst_hi = 0; rel_cnt = 0; idle = 0;
        pending = 1'b0; just_done = 1'b0; rel_active = 1'b0; prev_err = 1'b0; saw_break = 1'b1;
        cur_a = 6'd0; cur_d = 32'd0;
        mif.mgmt_waitrequest = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending = 1'b0; just_done = 1'b0; rel_active = 1'b0; saw_break = 1'b1;
                rst_hi = 0; prev_err = 1'b0; locked = 1'b0;
                mif.mgmt_waitrequest = 1'b0;
            end else begin
                if (just_done) begin
                    chk("write_drops", {63'd0, mif.mgmt_write}, 64'd0);
                    just_done = 1'b0;
                end
                if (mif.mgmt_write) begin
                    if (!pending) begin
                        if (!saw_break) chk("gap_cycles", 64'(idle), 64'd7);
                        pending = 1'b1; hold = 0;
                        cur_a = mif.mgmt_address; cur_d = mif.mgmt_writedata;
                    end else begin
                        chk("held_addr", {58'd0, mif.mgmt_address}, {58'd0, cur_a});
                        chk("held_data", {32'd0, mif.mgmt_writedata}, {32'd0, cur_d});
                    end
                    if (hold < wait_n) begin
                        mif.mgmt_waitrequest = 1'b1;
                        hold++;
                    end else begin
                        mif.mgmt_waitrequest = 1'b0;
                        pending = 1'b0; just_done = 1'b1; idle = 0; saw_break = 1'b0;
                        wr_done++;
                        if (sb.size() > 0) e = sb.pop_front();
                        else begin e.a = 6'h3F; e.d = 32'hFFFF_FFFF; end
                        chk("write_addr", {58'd0, mif.mgmt_address}, {58'd0, e.a});
                        chk("write_data", {32'd0, mif.mgmt_writedata}, {32'd0, e.d});
                    end
                end else begin
                    mif.mgmt_waitrequest = 1'b0;
                    idle++;
                end
                if (pll_reset) begin
                    rst_hi++; locked = 1'b0; rel_active = 1'b0;
                end else begin
                    if (rst_hi != 0) begin
                        chk("pll_reset_width", 64'(rst_hi), 64'd8);
                        rst_hi = 0; rel_active = 1'b1; rel_cnt = 0;
                    end else if (rel_active) begin
                        rel_cnt++;
                    end
                    if (rel_active && lock_ok && rel_cnt == 20) locked = 1'b1;
                end
                if (error && !prev_err) err_at = rel_cnt;
                prev_err = error;
                if (done) done_cnt++;
                if (pll_reset || !busy) saw_break = 1'b1;
            end
        end
    end

    // Runs one setting; entered and left on a falling clock edge.
    task automatic run_vec(input vec_t v, input bit poke_busy);
        int cyc, dc0;
        bit fin;
        push_expected(v);
        wait_n = v.wait_n; lock_ok = v.lock_ok; err_at = -1; dc0 = done_cnt;
        cfg_m = v.m; cfg_k = v.k; cfg_c = v.c; phase_base = v.base; phase_target = v.tgt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("error_cleared", {63'd0, error}, 64'd0);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        cfg_m = 32'hDEAD_BEEF; cfg_k = 32'h5555_AAAA; cfg_c = 32'h0F0F_0F0F;
        phase_base = 9'h1FF; phase_target = 9'h000;
        fin = 1'b0; cyc = 0;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = (poke_busy && cyc == 40) ? 1'b1 : 1'b0;
            if (done || error) fin = 1'b1;
        end
        start = 1'b0;
        chk("seq_finished", {63'd0, fin}, 64'd1);
        chk("done_flag", {63'd0, done}, {63'd0, v.exp_done});
        chk("error_flag", {63'd0, error}, {63'd0, v.exp_err});
        chk("busy_end", {63'd0, busy}, 64'd0);
        chk("writes_left", 64'(sb.size()), 64'd0);
        if (v.exp_err) begin
            @(negedge clk);
            chk("lock_timeout_cycles", 64'(err_at), 64'(LOCK_TO));
            repeat (30) @(negedge clk);
            chk("no_done_on_timeout", 64'(done_cnt), 64'(dc0));
            chk("no_phase_writes", 64'(sb.size()), 64'd0);
            chk("error_sticky", {63'd0, error}, 64'd1);
        end
    endtask

    initial begin : wdog
        #1000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t r;
        bit found;
        int wr0;
        vecs[0] = '{m:32'h808, k:32'hB333_32DD, c:32'h20302, base:9'd29, tgt:9'd29, wait_n:0,
                    lock_ok:1'b1, exp_done:1'b1, exp_err:1'b0};
        vecs[1] = '{m:32'h808, k:32'hB333_32DD, c:32'h20302, base:9'd29, tgt:9'd31, wait_n:0,
                    lock_ok:1'b1, exp_done:1'b1, exp_err:1'b0};
        vecs[2] = '{m:32'h808, k:32'hB333_32DD, c:32'h20302, base:9'd29, tgt:9'd20, wait_n:0,
                    lock_ok:1'b1, exp_done:1'b1, exp_err:1'b0};
        vecs[3] = '{m:32'h1010, k:32'h1234_5678, c:32'h0404, base:9'd10, tgt:9'd3, wait_n:5,
                    lock_ok:1'b1, exp_done:1'b1, exp_err:1'b0};
        vecs[4] = '{m:32'h606, k:32'h0, c:32'h10303, base:9'd0, tgt:9'd5, wait_n:0,
                    lock_ok:1'b0, exp_done:1'b0, exp_err:1'b1};
        vecs[5] = '{m:32'hA0A, k:32'h0, c:32'h10101, base:9'd0, tgt:9'd511, wait_n:1,
                    lock_ok:1'b1, exp_done:1'b1, exp_err:1'b0};

        repeat (3) @(negedge clk);
        chk("rst_write", {63'd0, mif.mgmt_write}, 64'd0);
        chk("rst_pll_reset", {63'd0, pll_reset}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_addr", {58'd0, mif.mgmt_address}, 64'd0);
        chk("idle_data", {32'd0, mif.mgmt_writedata}, 64'd0);

        // Back to back: each start is driven in the cycle its predecessor's done is high.
        run_vec(vecs[0], 1'b0);
        run_vec(vecs[1], 1'b1);
        run_vec(vecs[2], 1'b0);
        run_vec(vecs[3], 1'b0);
        run_vec(vecs[4], 1'b0);
        run_vec(vecs[5], 1'b0);
        repeat (5) @(negedge clk);

        // Asynchronous reset while the C1 write is stalled.
        r = vecs[0];
        r.wait_n = 3;
        push_expected(r);
        wait_n = 3; lock_ok = 1'b1;
        cfg_m = r.m; cfg_k = r.k; cfg_c = r.c; phase_base = r.base; phase_target = r.tgt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (mif.mgmt_write && mif.mgmt_address == 6'd5 && mif.mgmt_writedata == (r.c | 32'h0004_0000))
                found = 1'b1;
        end
        chk("c1_write_seen", {63'd0, found}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_write", {63'd0, mif.mgmt_write}, 64'd0);
        chk("async_addr", {58'd0, mif.mgmt_address}, 64'd0);
        chk("async_data", {32'd0, mif.mgmt_writedata}, 64'd0);
        chk("async_busy", {63'd0, busy}, 64'd0);
        chk("async_pll_reset", {63'd0, pll_reset}, 64'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wr0 = wr_done;
        repeat (100) @(negedge clk);
        chk("no_writes_after_reset", 64'(wr_done), 64'(wr0));
        chk("idle_after_reset", {63'd0, busy}, 64'd0);
        chk("no_pll_reset_after_reset", {63'd0, pll_reset}, 64'd0);

        run_vec(vecs[2], 1'b0);
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
